// File: rtl/gpio_serial_loader.sv
// gpio_serial_loader: fetches one configuration word per pad from a register-file
// read port and shifts it, highest pad first and MSB first, into the daisy-chained
// GPIO control blocks, then issues a single parallel-load strobe.
module gpio_serial_loader #(
  parameter int NUM_PADS = 27,
  parameter int CFG_BITS = 13,
  parameter int CLK_DIV  = 1,
  // Guarded so a single-pad chain still gets a 1-bit address port.
  parameter int AW       = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                start,
  output logic [AW-1:0]       cfg_addr,
  input  logic [CFG_BITS-1:0] cfg_data,
  output logic                busy,
  output logic                done,
  output logic                serial_clock,
  output logic                serial_data_out,
  output logic                serial_load,
  output logic                serial_resetn
);

  localparam int BW = (CFG_BITS > 1) ? $clog2(CFG_BITS) : 1;
  localparam int PW = $clog2(2 * CLK_DIV);

  localparam logic [AW-1:0] PAD_LAST = AW'(NUM_PADS - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(CFG_BITS - 1);
  localparam logic [PW-1:0] PH_HALF  = PW'(CLK_DIV);
  localparam logic [PW-1:0] PH_LAST  = PW'(2 * CLK_DIV - 1);
  localparam logic [PW-1:0] LD_LAST  = PW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE, FETCH_A, FETCH_D, SHIFT, LOAD, DONE
  } state_t;

  state_t state_q, state_d;

  logic [AW-1:0]       pad_q, pad_d;
  logic [BW-1:0]       bit_q, bit_d;
  logic [PW-1:0]       ph_q, ph_d;   // phase within a bit, or cycles spent in LOAD
  logic [CFG_BITS-1:0] sr_q, sr_d;

  logic [AW-1:0] addr_q, addr_d;
  logic busy_q, busy_d, done_q, done_d, sclk_q, sclk_d;
  logic sdo_q, sdo_d, load_q, load_d, rstn_q;

  // State, datapath and registered outputs; reset aborts without ever loading.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      pad_q   <= '0;
      bit_q   <= '0;
      ph_q    <= '0;
      sr_q    <= '0;
      addr_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sclk_q  <= 1'b0;
      sdo_q   <= 1'b0;
      load_q  <= 1'b0;
      rstn_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pad_q   <= pad_d;
      bit_q   <= bit_d;
      ph_q    <= ph_d;
      sr_q    <= sr_d;
      addr_q  <= addr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sclk_q  <= sclk_d;
      sdo_q   <= sdo_d;
      load_q  <= load_d;
      rstn_q  <= 1'b1;
    end
  end

  // Next-state sequencing: fetch address, fetch data, shift word, repeat per pad.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = FETCH_A;
      FETCH_A: state_d = FETCH_D;
      FETCH_D: state_d = SHIFT;
      SHIFT:   if (ph_q == PH_LAST && bit_q == '0)
                 state_d = (pad_q != '0) ? FETCH_A : LOAD;
      LOAD:    if (ph_q == LD_LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Counters and next output values; outputs are derived from the next state so
  // every port comes straight from a flop.
  always_comb begin
    pad_d = pad_q;
    bit_d = bit_q;
    ph_d  = ph_q;
    sr_d  = sr_q;
    case (state_q)
      IDLE:    if (start) pad_d = PAD_LAST;
      FETCH_D: begin
        sr_d  = cfg_data;
        bit_d = BIT_LAST;
        ph_d  = '0;
      end
      SHIFT: begin
        if (ph_q == PH_LAST) begin
          ph_d = '0;
          sr_d = sr_q << 1;
          if (bit_q != '0)      bit_d = bit_q - 1'b1;
          else if (pad_q != '0) pad_d = pad_q - 1'b1;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      LOAD:    ph_d = ph_q + 1'b1;
      default: ;
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
    load_d = (state_d == LOAD);
    // Clock rises only in the second half of a bit, so data is settled a half
    // period before every rising edge seen by the chain.
    sclk_d = (state_d == SHIFT) && (ph_d >= PH_HALF);
    sdo_d  = sdo_q;
    if (state_d == SHIFT)     sdo_d = sr_d[CFG_BITS-1];
    else if (state_d == IDLE) sdo_d = 1'b0;
    addr_d = (state_d == FETCH_A) ? pad_d : addr_q;
  end

  assign cfg_addr        = addr_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign serial_clock    = sclk_q;
  assign serial_data_out = sdo_q;
  assign serial_load     = load_q;
  assign serial_resetn   = rstn_q;

endmodule
